// File: rtl/if_stage_sram.sv
// Instruction-fetch stage: owns the PC, issues one SRAM fetch at a time and
// buffers the fetched instruction for decode; branch cancels redirect the PC.
module if_stage_sram #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_reqPc;
    logic [31:0] r_fsPc;
    logic [31:0] r_instBuf;
    logic        r_drop;
    logic        r_brPend;
    logic [31:0] r_brTgt;
    logic        r_reqFromBr;
    logic        w_cancel;
    logic [31:0] w_redirPc;
    logic        w_reqOut;
    logic        w_validOut;
    logic        w_unused;

    assign w_cancel  = br_bus[33];
    assign w_unused  = br_bus[32];
    assign w_redirPc = w_cancel ? br_bus[31:0] : r_brTgt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = S_REQ;
            S_REQ:  if (inst_sram_addr_ok) w_next = S_WAIT;
            S_WAIT: if (inst_sram_data_ok) w_next = (!r_drop && !w_cancel) ? S_HOLD : S_REQ;
            S_HOLD: if (w_cancel || ds_allowin) w_next = S_REQ;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_reqOut   = 1'b0;
        w_validOut = 1'b0;
        case (r_state)
            S_REQ:   w_reqOut   = 1'b1;
            S_HOLD:  w_validOut = 1'b1;
            default: ;
        endcase
    end

    // r_reqFromBr remembers that the pending request is the redirect itself,
    // so its acceptance retires r_brPend; a later cancel makes it stale again.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_reqPc     <= RESET_PC;
            r_fsPc      <= 32'd0;
            r_instBuf   <= 32'd0;
            r_drop      <= 1'b0;
            r_brPend    <= 1'b0;
            r_brTgt     <= 32'd0;
            r_reqFromBr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_reqPc     <= RESET_PC;
                    r_reqFromBr <= 1'b0;
                end
                S_REQ: begin
                    if (inst_sram_addr_ok) begin
                        r_fsPc <= r_reqPc;
                        if (r_reqFromBr) r_brPend <= 1'b0;
                    end
                    if (w_cancel) begin
                        r_drop      <= 1'b1;
                        r_reqFromBr <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (!r_drop && !w_cancel) begin
                            r_instBuf <= inst_sram_rdata;
                        end else begin
                            r_drop      <= 1'b0;
                            r_reqPc     <= w_redirPc;
                            r_reqFromBr <= 1'b1;
                        end
                    end else if (w_cancel) begin
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_cancel) begin
                        r_reqPc     <= w_redirPc;
                        r_reqFromBr <= 1'b1;
                    end else if (ds_allowin) begin
                        r_reqPc     <= r_brPend ? r_brTgt : r_fsPc + 32'd4;
                        r_reqFromBr <= r_brPend;
                    end
                end
                default: ;
            endcase
            if (w_cancel) begin
                r_brTgt  <= br_bus[31:0];
                r_brPend <= 1'b1;
            end
        end
    end

    assign fs_to_ds_valid  = w_validOut;
    assign fs_to_ds_bus    = {r_instBuf, r_fsPc};
    assign inst_sram_req   = w_reqOut;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_addr  = r_reqPc;
    assign inst_sram_wdata = 32'd0;

endmodule

// File: doc/if_stage_sram.md
# if_stage_sram

Instruction-fetch stage placed directly upstream of the decode stage. It owns the PC and issues one instruction fetch at a time over an SRAM-like request/response interface. Each fetched instruction is buffered and presented to decode through the `fs_to_ds_valid` / `ds_allowin` handshake. Branch redirects arrive from decode on `br_bus`; they cancel the wrong-path fetch and redirect the PC.

## Interface
- `RESET_PC`, default 32'h1c000000, address of the first fetch after reset.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ds_allowin`  in  1  decode can accept an instruction this cycle.
- `br_bus`  in  34  {br_taken_cancel[33], br_taken[32], br_target[31:0]}; a redirect is acted on only when bit 33 is 1.
- `fs_to_ds_valid`  out  1  `fs_to_ds_bus` holds a valid instruction.
- `fs_to_ds_bus`  out  64  {inst[63:32], pc[31:0]}.
- `inst_sram_req`  out  1  fetch request.
- `inst_sram_wr`  out  1  constant 0.
- `inst_sram_size`  out  2  constant 2'd2 (word).
- `inst_sram_wstrb`  out  4  constant 0.
- `inst_sram_addr`  out  32  fetch address.
- `inst_sram_wdata`  out  32  constant 0.
- `inst_sram_addr_ok`  in  1  request accepted.
- `inst_sram_data_ok`  in  1  response valid.
- `inst_sram_rdata`  in  32  response instruction.

## Operation
- FSM states:
  - IDLE (reset only).
  - REQ (`inst_sram_req` = 1).
  - WAIT (one request outstanding).
  - HOLD (instruction buffered, `fs_to_ds_valid` = 1).
- Registers:
  - `req_pc`: the address being requested; drives `inst_sram_addr`.
  - `fs_pc` and `inst_buf`: the pc and instruction output on `fs_to_ds_bus`.
  - `drop`: marks the outstanding response as wrong-path.
  - `br_pend` and `br_tgt`: a redirect not yet requested.
- IDLE → REQ unconditionally, with `req_pc` = `RESET_PC`.
- REQ: `inst_sram_addr` stays stable while `req` is high. On `addr_ok`:
  - go to WAIT;
  - latch `fs_pc` <= `req_pc`;
  - clear `br_pend` if `req_pc` was loaded from `br_tgt`.
- WAIT, on `data_ok`:
  - if `drop` is 0 and there is no cancel this cycle: `inst_buf` <= `inst_sram_rdata`, go to HOLD;
  - otherwise: discard the response, clear `drop`, go to REQ with `req_pc` = `br_tgt`.
- HOLD, when `ds_allowin` = 1 and there is no cancel: transfer the instruction, then go to REQ with `req_pc` = `br_pend` ? `br_tgt` : `fs_pc` + 4 (32-bit wrap).
- Cancel (`br_bus[33]` = 1) always latches `br_tgt` <= `br_bus[31:0]` and sets `br_pend`. Its further effect depends on state:
  - REQ: the current request still completes, because the address cannot change mid-request. `drop` is set, so the response is discarded.
  - Cancel in the same cycle as `addr_ok`: go to WAIT with `drop` = 1.
  - WAIT: set `drop`. A cancel in the same cycle as `data_ok` discards that data.
  - HOLD: clear `fs_to_ds_valid` next cycle and go to REQ with `req_pc` = the new target. This holds even if `ds_allowin` = 1 in the same cycle; cancel has priority and the instruction is not considered transferred.
  - A second cancel before the redirect is requested overwrites `br_tgt`.
- At most one request outstanding; `req` is never asserted in WAIT or HOLD.

## Timing
- Reset values:
  - `fs_to_ds_valid` = 0, `inst_sram_req` = 0, `inst_sram_addr` = `RESET_PC`, `fs_to_ds_bus` = 0;
  - `drop` = 0, `br_pend` = 0, state = IDLE.
- First `inst_sram_req` is asserted in the 2nd rising edge's cycle after `resetn` deasserts (IDLE lasts one cycle).
- Best case, with `addr_ok` in the REQ cycle, `data_ok` in the next cycle and `ds_allowin` = 1:
  - REQ at cycle n;
  - WAIT at cycle n+1;
  - `fs_to_ds_valid` at cycle n+2;
  - next REQ at cycle n+3.
- Throughput is therefore one instruction per 3 cycles.
- `fs_to_ds_valid` is a pure register output; there is no combinational path from SRAM inputs to it.
- Reset asserted mid-operation returns to the reset values immediately. Any in-flight SRAM response after reset is not expected (the SRAM shares `resetn`).

## Test plan
- **Reset and first fetch:** release `resetn`, with `addr_ok` and `data_ok` each 1 cycle after request. Required:
  - `req` rises one cycle after release with address 0x1c000000;
  - `fs_to_ds_bus` = {rdata, 0x1c000000} with valid 2 cycles after `addr_ok`.
- **Sequential stream:** `ds_allowin` = 1 throughout. Required:
  - addresses 0x1c000000, 0x1c000004, 0x1c000008;
  - each presented exactly once, 3 cycles apart.
- **Backpressure:** `ds_allowin` = 0 for 5 cycles in HOLD. Required:
  - valid and bus held constant;
  - no `req` until `ds_allowin` = 1;
  - then the next address is `fs_pc` + 4.
- **Cancel in WAIT:** cancel with target 0x1c000100 while awaiting `data_ok`. Required:
  - the response is not presented (valid stays 0);
  - the next `req` has address 0x1c000100.
- **Cancel in HOLD with `ds_allowin` = 1:** Required:
  - valid drops the next cycle;
  - the next `req` address equals the target, not `fs_pc` + 4.
- **Cancel in REQ with delayed `addr_ok` (3 cycles):** Required:
  - the address stays at the old value until `addr_ok`;
  - the response is dropped;
  - the following `req` is at the target.
  - Also assert `resetn` low mid-WAIT: outputs return to the reset values immediately.
